clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Programmable integer clock divider that generates the low-frequency, glitch-free control waveform fed into a high-drive buffer stage (input I of the buffer_24x-style driver).
- Fully registered output, so the downstream buffer only ever sees a clean flop-driven edge.
- Divide ratio changes only at period boundaries.
- Stopping never produces a runt pulse.

Parameters:
- WIDTH, 4, width of the divide-ratio input and internal counter. Supported ratios are 2..2^WIDTH-1.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  run request, sampled every cycle.
- DIV  input  WIDTH  requested divide ratio. Values 0 and 1 are treated as 2.
- O  output  1  divided output, registered; drives the downstream buffer input.
- TICK  output  1  one-cycle pulse, high in the first cycle of each O high phase.
- BUSY  output  1  high while a period is in progress (state RUN).
- CNT  output  WIDTH  current position within the period, registered.

Behaviour:
- Reset (RST=1 at a CLK edge) sets: state=IDLE, CNT=0, O=0, TICK=0, BUSY=0, active ratio R=2.
- RST has priority over every other input, including mid-period. O drops to 0 at that same edge.
- Derived values:
  - R = max(DIV,2), latched only at period start.
  - H = floor(R/2), using the latched R.
- State IDLE:
  - Holds CNT=0, O=0, TICK=0, BUSY=0.
  - If EN=1, the next edge enters RUN with CNT=0, O=1, TICK=1, BUSY=1, and latches R from DIV.
  - Latency from EN rising to O rising is 1 edge.
- State RUN, at each edge with current count c:
  - If c < R-1: CNT=c+1, O=(c+1 < H), TICK=0.
  - If c == R-1 and EN=1: wrap. CNT=0, O=1, TICK=1, R relatched from the current DIV.
  - If c == R-1 and EN=0: go to IDLE. CNT=0, O=0, TICK=0, BUSY=0.
- EN deasserted mid-period has no effect until the period completes. The current period always finishes in full, so no truncated high or low phase occurs.
- Waveform per period: O high for H cycles, low for R-H cycles.
  - Even R gives 50% duty.
  - Odd R has the low phase one cycle longer (R=3: 1 high/2 low; R=5: 2 high/3 low).
- DIV changes mid-period are ignored until the next wrap. No glitch or partial period results.
- O, TICK, BUSY and CNT are all flop outputs. There is no combinational path from any input to any output.
- Counter never exceeds R-1. The latched R is never below 2.

Test Plan:
1. RST=1 for 2 cycles with EN=1 and DIV=4 → O=0, TICK=0, BUSY=0, CNT=0 throughout. After release, O rises 1 edge later and then runs at 2 high/2 low.
2. DIV=5, EN held high for 3 periods → O pattern 1,1,0,0,0 repeating. TICK high only on cycles with CNT=0. BUSY stays 1.
3. DIV=0, then DIV=1 → both behave as ratio 2: O toggles 1,0,1,0 and TICK=1 every other cycle.
4. DIV=6 running; at CNT=2 change DIV to 3 → current period completes with 3 high/3 low. The next period is 1 high/2 low.
5. DIV=7; drop EN at CNT=1 → O completes the 3-high/4-low period, then goes to IDLE with BUSY=0 after the CNT=6 edge. No further TICK.
6. DIV=15 (max); assert RST at CNT=4 → at the next edge O=0, CNT=0, BUSY=0. With EN=1 on release, a fresh period starts with 7 high/8 low.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a registered, glitch-free output.
// The divide ratio is latched only at period start, and stopping waits for the period boundary.
module clk_div_prog #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    output logic             O,
    output logic             TICK,
    output logic             BUSY,
    output logic [WIDTH-1:0] CNT
);

    localparam int unsigned MIN_RATIO = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             o_q, o_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] div_sat_c;
    logic [WIDTH-1:0] half_c;
    logic [WIDTH-1:0] cnt_inc_c;
    logic             last_c;

    // Ratios 0 and 1 collapse to the minimum legal ratio.
    assign div_sat_c = (DIV < WIDTH'(MIN_RATIO)) ? WIDTH'(MIN_RATIO) : DIV;
    assign half_c    = ratio_q >> 1;
    assign cnt_inc_c = cnt_q + WIDTH'(1);
    assign last_c    = (cnt_q == ratio_q - WIDTH'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        o_d     = o_q;
        tick_d  = 1'b0;

        if (state_q == IDLE) begin
            cnt_d = '0;
            o_d   = 1'b0;
            if (EN) begin
                state_d = RUN;
                o_d     = 1'b1;
                tick_d  = 1'b1;
                ratio_d = div_sat_c;
            end
        end else begin
            if (!last_c) begin
                cnt_d = cnt_inc_c;
                o_d   = (cnt_inc_c < half_c);
            end else if (EN) begin
                cnt_d   = '0;
                o_d     = 1'b1;
                tick_d  = 1'b1;
                ratio_d = div_sat_c;
            end else begin
                // Full period done and no run request: park without a runt pulse.
                state_d = IDLE;
                cnt_d   = '0;
                o_d     = 1'b0;
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= WIDTH'(MIN_RATIO);
            o_q     <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            o_q     <= o_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign O    = o_q;
    assign TICK = tick_q;
    assign BUSY = busy_q;
    assign CNT  = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: reference model feeds an expected-value queue,
// plus directed waveform checks for each scenario.
module tb_clk_div_prog;

    localparam int unsigned WIDTH = 4;

    logic             CLK;
    logic             RST;
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             O;
    logic             TICK;
    logic             BUSY;
    logic [WIDTH-1:0] CNT;

    typedef struct packed {
        logic             o;
        logic             tick;
        logic             busy;
        logic [WIDTH-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state, starts at the reset values
    logic             m_run  = 1'b0;
    logic [WIDTH-1:0] m_cnt  = '0;
    logic [WIDTH-1:0] m_r    = 4'd2;
    logic             m_o    = 1'b0;
    logic             m_tick = 1'b0;

    clk_div_prog #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .DIV  (DIV),
        .O    (O),
        .TICK (TICK),
        .BUSY (BUSY),
        .CNT  (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] d);
        return (d < 4'd2) ? 4'd2 : d;
    endfunction

    task automatic model(input logic rst, input logic en, input logic [WIDTH-1:0] div);
        if (rst) begin
            m_run = 0; m_cnt = 0; m_r = 4'd2; m_o = 0; m_tick = 0;
        end else if (!m_run) begin
            m_cnt = 0; m_tick = 0; m_o = 0;
            if (en) begin
                m_run = 1; m_o = 1; m_tick = 1; m_r = sat(div);
            end
        end else if (32'(m_cnt) + 1 < 32'(m_r)) begin
            m_cnt  = m_cnt + 4'd1;
            m_o    = (32'(m_cnt) < 32'(m_r) / 2);
            m_tick = 0;
        end else if (en) begin
            m_cnt = 0; m_o = 1; m_tick = 1; m_r = sat(div);
        end else begin
            m_run = 0; m_cnt = 0; m_o = 0; m_tick = 0;
        end
    endtask

    // One clock: drive inputs on the falling edge, predict, then compare just after the rising edge.
    task automatic step(input logic rst, input logic en, input logic [WIDTH-1:0] div);
        exp_t e;
        @(negedge CLK);
        RST = rst;
        EN  = en;
        DIV = div;
        model(rst, en, div);
        exp_q.push_back('{o: m_o, tick: m_tick, busy: m_run, cnt: m_cnt});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check("sb_o",    32'(O),    32'(e.o));
        check("sb_tick", 32'(TICK), 32'(e.tick));
        check("sb_busy", 32'(BUSY), 32'(e.busy));
        check("sb_cnt",  32'(CNT),  32'(e.cnt));
    endtask

    logic [11:0] pat4;
    logic [6:0]  pat5;

    initial begin
        RST = 1'b1;
        EN  = 1'b0;
        DIV = '0;
        pat4 = 12'b111000100100;
        pat5 = 7'b1110000;

        // 1: reset held with EN=1, DIV=4
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 4'd4);
            check("rst_o", 32'(O), 0);
            check("rst_busy", 32'(BUSY), 0);
            check("rst_cnt", 32'(CNT), 0);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'd4);
            check("div4_o", 32'(O), 32'((i % 4) < 2));
        end

        // 2: ratio 5, three periods
        step(1, 0, 4'd5);
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 4'd5);
            check("div5_o", 32'(O), 32'((i % 5) < 2));
            check("div5_tick", 32'(TICK), 32'(CNT == 0));
            check("div5_busy", 32'(BUSY), 1);
        end

        // 3: DIV=0 then DIV=1 both act as ratio 2
        step(1, 0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, (i < 4) ? 4'd0 : 4'd1);
            check("div01_o", 32'(O), 32'((i % 2) == 0));
            check("div01_tick", 32'(TICK), 32'((i % 2) == 0));
        end

        // 4: ratio 6, switch to 3 at CNT=2
        step(1, 0, 4'd6);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, (i < 3) ? 4'd6 : 4'd3);
            check("div6to3_o", 32'(O), 32'(pat4[11-i]));
        end

        // 5: ratio 7, EN dropped at CNT=1
        step(1, 0, 4'd7);
        for (int i = 0; i < 7; i++) begin
            step(0, (i < 2), 4'd7);
            check("stop_o", 32'(O), 32'(pat5[6-i]));
            check("stop_busy", 32'(BUSY), 1);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'd7);
            check("stop_idle_busy", 32'(BUSY), 0);
            check("stop_idle_tick", 32'(TICK), 0);
            check("stop_idle_o", 32'(O), 0);
        end

        // 6: ratio 15, reset at CNT=4, then fresh period
        step(1, 0, 4'd15);
        for (int i = 0; i < 5; i++) step(0, 1, 4'd15);
        check("max_cnt_pre", 32'(CNT), 4);
        step(1, 1, 4'd15);
        check("max_rst_o", 32'(O), 0);
        check("max_rst_cnt", 32'(CNT), 0);
        check("max_rst_busy", 32'(BUSY), 0);
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 4'd15);
            check("max_o", 32'(O), 32'(i < 7));
            check("max_cnt", 32'(CNT), 32'(i));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
